// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotated-priority picker: searches ptr+1, ptr+2, ptr+3, ptr.
import mux_arb_pkg::*;

module rr_pick (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux between four requesters, with a
// hold limit that forces rotation when others are waiting.
import mux_arb_pkg::*;

module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data_in,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       valid,
    output logic       data_out
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    state_t           state, state_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [SEL_W-1:0] sel_n;
    logic [N_REQ-1:0] grant_n;
    logic             valid_n;

    logic             found;
    logic [SEL_W-1:0] win;
    logic             competitor;
    logic             take;

    // While granted, ptr equals sel, so the same picker serves both the
    // initial grant and rotation: the current grantee is searched last.
    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ptr      <= 2'd3;
            sel      <= '0;
            grant    <= '0;
            valid    <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            grant    <= grant_n;
            valid    <= valid_n;
        end
    end

    always_comb begin
        state_n    = state;
        hold_n     = hold_cnt;
        ptr_n      = ptr;
        sel_n      = sel;
        grant_n    = grant;
        valid_n    = valid;
        take       = 1'b0;
        competitor = |(req & ~onehot(sel));

        case (state)
            IDLE: begin
                if (found) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    // Release wins over hold expiry.
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        state_n = IDLE;
                        hold_n  = '0;
                        sel_n   = '0;
                        grant_n = '0;
                        valid_n = 1'b0;
                    end
                end else if (hold_cnt == HOLD_MAX && competitor) begin
                    take = 1'b1;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (take) begin
            state_n = GRANT;
            hold_n  = HOLD_ONE;
            ptr_n   = win;
            sel_n   = win;
            grant_n = onehot(win);
            valid_n = 1'b1;
        end
    end

    assign data_out = valid & data_in[sel];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed table-driven bench for mux_rr_arbiter, plus hand sequences for
// mid-grant reset and the MAX_HOLD=1 configuration.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       data_out;

    logic       rst1_n;
    logic [3:0] req1;
    logic [3:0] data_in1;
    logic [3:0] grant1;
    logic [1:0] sel1;
    logic       valid1;
    logic       data_out1;

    int total;
    int bad;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
    } vec_t;

    vec_t tbl[$];

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .sel      (sel),
        .valid    (valid),
        .data_out (data_out)
    );

    mux_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst1_n),
        .req      (req1),
        .data_in  (data_in1),
        .grant    (grant1),
        .sel      (sel1),
        .valid    (valid1),
        .data_out (data_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] d,
                       input logic [3:0] g, input logic [1:0] s, input logic v, input int n);
        vec_t e;
        e.rst_n = r; e.req = q; e.din = d; e.g = g; e.s = s; e.v = v;
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    task automatic check_main(input string tag, input int idx, input logic [3:0] g,
                              input logic [1:0] s, input logic v, input logic [3:0] d);
        logic [3:0] dv;
        logic       dexp;
        dv   = d;
        dexp = v ? dv[s] : 1'b0;
        chk({tag, ".grant"}, idx, grant, g);
        chk({tag, ".sel"}, idx, {2'b00, sel}, {2'b00, s});
        chk({tag, ".valid"}, idx, {3'b000, valid}, {3'b000, v});
        chk({tag, ".data_out"}, idx, {3'b000, data_out}, {3'b000, dexp});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        req      = '0;
        data_in  = '0;
        rst1_n   = 1'b0;
        req1     = '0;
        data_in1 = '0;

        // reset with everything asserted
        add(0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 3);
        // single requester keeps the grant past MAX_HOLD
        add(1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 10);
        // competitor arrives once hold_cnt is saturated: rotates at once
        add(1, 4'b0110, 4'b0110, 4'b0010, 2'd1, 1, 1);
        add(1, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0, 1);
        // full contention, four cycles each, then wrap
        add(0, 4'b1111, 4'b1010, 4'b0000, 2'd0, 0, 1);
        add(1, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1, 4);
        add(1, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1, 4);
        add(1, 4'b1111, 4'b1010, 4'b0100, 2'd2, 1, 4);
        add(1, 4'b1111, 4'b1010, 4'b1000, 2'd3, 1, 4);
        add(1, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1, 1);
        // early release hands over without an idle cycle
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 1);
        add(1, 4'b1011, 4'b0101, 4'b0001, 2'd0, 1, 2);
        add(1, 4'b1010, 4'b0101, 4'b0010, 2'd1, 1, 4);
        add(1, 4'b1010, 4'b0101, 4'b1000, 2'd3, 1, 1);
        // wrap and skip, then idle
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 1);
        add(1, 4'b0010, 4'b1111, 4'b0010, 2'd1, 1, 1);
        add(1, 4'b0001, 4'b1111, 4'b0001, 2'd0, 1, 1);
        add(1, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0, 1);
        // drop and re-raise while granted: the other requester goes first
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 1);
        add(1, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1, 1);
        add(1, 4'b1000, 4'b0001, 4'b1000, 2'd3, 1, 1);
        add(1, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1, 3);
        add(1, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n   = tbl[i].rst_n;
            req     = tbl[i].req;
            data_in = tbl[i].din;
            @(posedge clk);
            #1;
            check_main("tbl", i, tbl[i].g, tbl[i].s, tbl[i].v, tbl[i].din);
        end

        // reset in mid-grant with hold_cnt=3
        rst_n = 1'b0; req = 4'b0000; data_in = 4'b0100;
        @(posedge clk); #1;
        rst_n = 1'b1; req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_main("midrst.hold", i, 4'b0100, 2'd2, 1'b1, data_in);
        end
        rst_n = 1'b0; req = 4'b1111;
        @(posedge clk); #1;
        check_main("midrst.reset", 0, 4'b0000, 2'd0, 1'b0, data_in);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_main("midrst.first", 0, 4'b0001, 2'd0, 1'b1, data_in);

        // MAX_HOLD=1 rotates every cycle under contention
        rst1_n = 1'b0; req1 = 4'b0011; data_in1 = 4'b0010;
        @(posedge clk); #1;
        chk("mh1.reset", 0, grant1, 4'b0000);
        rst1_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mh1.grant", i, grant1, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            chk("mh1.data_out", i, {3'b000, data_out1}, (i % 2 == 0) ? 4'b0000 : 4'b0001);
        end
        req1 = 4'b0000;
        @(posedge clk); #1;
        chk("mh1.idle", 0, {3'b000, valid1}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
